// File: rtl/switchbox_cfg_loader.sv
// Framed route-word loader for the switch box; all routes commit atomically on a good checksum.
// Commit lands on the checksum edge (done one cycle later); cfg_ready is state-only, so cfg_valid may stall freely.
module switchbox_cfg_loader #(
  parameter int NTOP  = 5,
  parameter int NSIDE = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [7:0]           cfg_data,
  output logic [6*NTOP-1:0]    cfg_top,
  output logic [6*NTOP-1:0]    cfg_bottom,
  output logic [6*NSIDE-1:0]   cfg_left,
  output logic [6*NSIDE-1:0]   cfg_right,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int N = 2*NTOP + 2*NSIDE;
  localparam int W = 6*N;
  localparam logic [4:0] NLAST = 5'(N-1);
  localparam logic [7:0] HDR_BYTE = 8'hA5;

  typedef enum logic [1:0] {IDLE, HDR, DATA, CSUM} state_t;

  state_t       state, state_nxt;
  logic [4:0]   cnt;
  logic [7:0]   xacc;
  logic [W-1:0] shadow;
  logic         xfer, wr, commit, fail;

  function automatic logic legal(input logic [7:0] b);
    logic ok;
    int   idx;
    idx = int'(b[5:3]);
    ok  = 1'b0;
    if (b[7:6] == 2'b00) begin
      case (b[2:0])
        3'd0:       ok = 1'b1;
        3'd1, 3'd3: ok = (idx < NTOP);
        3'd2, 3'd4: ok = (idx < NSIDE);
        default:    ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  assign cfg_ready = (state != IDLE);
  assign busy      = (state != IDLE);
  assign xfer      = cfg_valid & cfg_ready;

  always_comb begin
    state_nxt = state;
    wr        = 1'b0;
    commit    = 1'b0;
    fail      = 1'b0;
    if (start) begin
      // start wins over a byte accepted in the same cycle; that byte is dropped
      state_nxt = HDR;
    end else if (xfer) begin
      case (state)
        HDR: begin
          if (cfg_data == HDR_BYTE) state_nxt = DATA;
          else begin
            fail      = 1'b1;
            state_nxt = IDLE;
          end
        end
        DATA: begin
          if (legal(cfg_data)) begin
            wr = 1'b1;
            if (cnt == NLAST) state_nxt = CSUM;
          end else begin
            fail      = 1'b1;
            state_nxt = IDLE;
          end
        end
        CSUM: begin
          if (cfg_data == xacc) commit = 1'b1;
          else fail = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      xacc       <= '0;
      shadow     <= '0;
      cfg_top    <= '0;
      cfg_bottom <= '0;
      cfg_left   <= '0;
      cfg_right  <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= commit;
      if (start) begin
        err  <= 1'b0;
        cnt  <= '0;
        xacc <= '0;
      end else begin
        if (fail) err <= 1'b1;
        if (wr) begin
          cnt  <= cnt + 5'd1;
          xacc <= xacc ^ cfg_data;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (wr && cnt == 5'(i)) shadow[6*i +: 6] <= cfg_data[5:0];
      end
      if (commit) begin
        cfg_top    <= shadow[0 +: 6*NTOP];
        cfg_bottom <= shadow[6*NTOP +: 6*NTOP];
        cfg_left   <= shadow[12*NTOP +: 6*NSIDE];
        cfg_right  <= shadow[12*NTOP + 6*NSIDE +: 6*NSIDE];
      end
    end
  end

endmodule

// File: doc/switchbox_cfg_loader.md
# switchbox_cfg_loader

Configuration loader for the 4-sided routing switch box. It accepts a framed byte stream over a valid/ready handshake and validates every route word and a checksum. On success it commits all route words atomically to the switch box's per-pin select registers; a failed load never disturbs the active routing. It sits between the configuration port and the switch box, and is the writer for the 6-bit per-pin route words the switch box decodes.

## Interface
- NTOP, 5, pins on top side and on bottom side
- NSIDE, 4, pins on left side and on right side
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous reset, active low
- start  in  1  begin a load; restarts a load already in progress
- cfg_valid  in  1  cfg_data valid
- cfg_ready  out  1  loader accepts a byte this cycle
- cfg_data  in  8  stream byte
- cfg_top  out  6*NTOP  active route words, pin i at [6i+5:6i]
- cfg_bottom  out  6*NTOP  same layout
- cfg_left  out  6*NSIDE  same layout
- cfg_right  out  6*NSIDE  same layout
- busy  out  1  load in progress
- done  out  1  one-cycle pulse after a successful commit
- err  out  1  last load failed; sticky until next start

## Operation
- Route word format: [2:0] source side (0 = disconnected/Z, 1 = top, 2 = right, 3 = bottom, 4 = left); [5:3] source pin index.
- Frame, in order:
  - header 0xA5;
  - N = 2*NTOP + 2*NSIDE data bytes (18 at defaults), ordered top[0..NTOP-1], bottom[0..], left[0..], right[0..];
  - checksum byte = XOR of all N data bytes (header excluded).
- A data byte is legal only if all of the following hold:
  - bits [7:6] = 0;
  - side is in 0..4;
  - side 1 or 3 requires index < NTOP;
  - side 2 or 4 requires index < NSIDE;
  - side 0 accepts any index.
- Legal data bytes go into the shadow registers; the running XOR accumulates them.
- FSM states: IDLE, HDR, DATA, CSUM.
  - IDLE: cfg_ready=0; start -> HDR.
  - HDR: header accepted = 0xA5 -> DATA; any other value -> error.
  - DATA: each accepted legal byte increments the word counter; the Nth word -> CSUM; an illegal byte -> error.
  - CSUM: an accepted byte equal to the running XOR -> commit; otherwise -> error.
- Commit: at the accepting edge, all cfg_* outputs load from shadow simultaneously, done pulses, and the FSM returns to IDLE.
- Error: FSM returns to IDLE, err=1, and cfg_* keep their previous values. The shadow contents are don't-care.
- start in any state:
  - clears err, the word counter and the XOR accumulator;
  - FSM -> HDR.
  - start has priority over a byte accepted in the same cycle; that byte is discarded.
- busy = (state != IDLE). cfg_ready = (state in HDR, DATA, CSUM).
- Word counter: 5 bits, never wraps; it exits DATA at exactly N.

## Timing
- Reset (async assert, sync-free deassert use): state=IDLE, all cfg_* = 0 (every pin Z in the switch box), shadow=0, counter=0, XOR=0, busy=0, done=0, err=0, cfg_ready=0.
- Reset mid-load: the load is abandoned and all outputs return to their reset values, including previously committed routing.
- A byte transfers on a rising edge where cfg_valid & cfg_ready. cfg_valid may drop at any time with no penalty; cfg_ready is state-derived only and does not depend on cfg_valid.
- start sampled at edge k: busy=1 and cfg_ready=1 from cycle k+1.
- Minimum load is 1 start cycle plus N+2 transfer edges (21 edges at defaults).
- cfg_* change at the checksum-accepting edge. done=1 and busy=0 for exactly the following cycle.
- err asserts in the cycle after the offending byte's accepting edge; busy=0 and cfg_ready=0 in that same cycle.

## Test plan
- Reset: assert rst_n=0 mid-frame -> cfg_* all 0, busy=0, err=0, cfg_ready=0 immediately, without waiting for a clock.
- Good load: start, then 0xA5; top[0]=0x0A (right[1]); left[3]=0x1B (bottom[3]); all other words 0x00; checksum 0x11 -> done pulses once; cfg_top[5:0]=0x0A, cfg_left[23:18]=0x1B, all other fields 0; err=0.
- Backpressure: repeat the good load with cfg_valid toggled pseudo-randomly -> identical result; no byte duplicated or dropped.
- Bad checksum: the same frame with checksum 0x10 -> err=1, done never asserts, cfg_* still hold the previous good load.
- Illegal words, each in a separate frame:
  - 0x22 (right index 4), 0x29 (top index 5), 0x05 (side 5), 0x40 (bit 6 set) -> err=1 in the cycle after that byte is accepted; busy=0 and cfg_ready=0 from then on.
- Bad header: first byte 0x5A -> err=1; a following start clears err and a correct frame then commits normally.
- Restart: start issued after 7 data bytes, followed by a complete new frame -> only the new frame is committed, and done pulses exactly once.
